// File: rtl/lfsr_bist_controller_if.sv
// ============================================================================
// Module   : lfsr_bist_controller_if
// Purpose  : Config/status and LFSR/CUT signal bundle for the BIST controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface lfsr_bist_controller_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] seed;
   logic [CNT_W-1:0] num_patterns;
   logic [WIDTH-1:0] golden_sig;
   logic             lfsr_load;
   logic [WIDTH-1:0] lfsr_seed;
   logic             lfsr_en;
   logic             cut_resp;
   logic             busy;
   logic             done;
   logic             pass;
   logic [WIDTH-1:0] signature;
   logic [CNT_W-1:0] pattern_count;

   // Controller side
   modport slave (
      input  start, abort, seed, num_patterns, golden_sig, cut_resp,
      output lfsr_load, lfsr_seed, lfsr_en, busy, done, pass,
             signature, pattern_count
   );

   // Test-access / LFSR+CUT environment side
   modport master (
      output start, abort, seed, num_patterns, golden_sig, cut_resp,
      input  lfsr_load, lfsr_seed, lfsr_en, busy, done, pass,
             signature, pattern_count
   );
endinterface

`default_nettype wire

// File: rtl/lfsr_bist_controller.sv
// ============================================================================
// Module   : lfsr_bist_controller
// Purpose  : Seeds and steps the LFSR, compacts CUT responses, checks signature.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module lfsr_bist_controller #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   lfsr_bist_controller_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SEED    = 3'd1,
      S_RUN     = 3'd2,
      S_COMPARE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] seed_q;
   logic [WIDTH-1:0] golden_q;
   logic [WIDTH-1:0] sig_q;
   logic [CNT_W-1:0] num_q;
   logic [CNT_W-1:0] cnt_q;
   logic             load_q;
   logic             en_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;

   logic [WIDTH-1:0] sig_next;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] last_idx;

   // Serial compaction: right shift, feedback from bit 0 into the top two bits
   assign sig_next = {sig_q[0] ^ bus.cut_resp, sig_q[WIDTH-1] ^ sig_q[0], sig_q[WIDTH-2:1]};
   assign cnt_inc  = cnt_q + 1'b1;
   assign last_idx = num_q - 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         seed_q   <= '0;
         golden_q <= '0;
         num_q    <= '0;
         sig_q    <= '0;
         cnt_q    <= '0;
         load_q   <= 1'b0;
         en_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else if (bus.abort) begin
         state  <= S_IDLE;
         load_q <= 1'b0;
         en_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  seed_q   <= bus.seed;
                  num_q    <= bus.num_patterns;
                  golden_q <= bus.golden_sig;
                  done_q   <= 1'b0;
                  pass_q   <= 1'b0;
                  busy_q   <= 1'b1;
                  load_q   <= 1'b1;
                  state    <= S_SEED;
               end
            end
            S_SEED: begin
               load_q <= 1'b0;
               sig_q  <= '0;
               cnt_q  <= '0;
               if (num_q == '0) begin
                  en_q  <= 1'b0;
                  state <= S_COMPARE;
               end else begin
                  // The final pattern is absorbed without stepping the LFSR
                  en_q  <= (num_q != {{(CNT_W-1){1'b0}}, 1'b1});
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               sig_q <= sig_next;
               cnt_q <= cnt_inc;
               if (cnt_q == last_idx) begin
                  en_q  <= 1'b0;
                  state <= S_COMPARE;
               end else begin
                  en_q  <= (cnt_inc != last_idx);
               end
            end
            S_COMPARE: begin
               done_q <= 1'b1;
               pass_q <= (sig_q == golden_q);
               busy_q <= 1'b0;
               state  <= S_DONE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.lfsr_load     = load_q;
   assign bus.lfsr_seed     = seed_q;
   assign bus.lfsr_en       = en_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.pass          = pass_q;
   assign bus.signature     = sig_q;
   assign bus.pattern_count = cnt_q;

endmodule

`default_nettype wire

// File: doc/lfsr_bist_controller.md
Name: lfsr_bist_controller

Overview:
Test-session sequencer for the bit-swapping LFSR pattern generator. It seeds the LFSR and steps it for a programmed number of patterns. Each cycle it compacts the 1-bit circuit-under-test response into a serial signature register, then compares the final signature against a golden value. It sits between the test-access/config logic and the LFSR + CUT pair, and owns the LFSR's load/enable controls.

Parameters:
WIDTH, 4, LFSR and signature width; legal range WIDTH >= 3.
CNT_W, 8, width of the pattern-count field.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  begin a session; sampled in IDLE or DONE only.
abort  input  1  cancel the session; returns to IDLE.
seed  input  WIDTH  LFSR seed; captured on an accepted start.
num_patterns  input  CNT_W  patterns to apply; captured on an accepted start.
golden_sig  input  WIDTH  expected signature; captured on an accepted start.
lfsr_load  output  1  one-cycle load strobe to the LFSR.
lfsr_seed  output  WIDTH  seed value driven to the LFSR; valid while lfsr_load=1.
lfsr_en  output  1  advance the LFSR one step at the next clock edge.
cut_resp  input  1  CUT response for the pattern currently held in the LFSR.
busy  output  1  session in progress (SEED, RUN or COMPARE).
done  output  1  level; session complete; held until the next accepted start.
pass  output  1  signature == golden; valid only while done=1, otherwise 0.
signature  output  WIDTH  current signature register contents.
pattern_count  output  CNT_W  responses absorbed so far in this session.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. All outputs are 0: lfsr_load, lfsr_en, busy, done, pass, signature, pattern_count, lfsr_seed. Captured registers are cleared.
- States:
  - IDLE / DONE:
    - start=1 and abort=0 -> capture seed/num_patterns/golden_sig, clear done/pass -> SEED.
    - In DONE, outputs are otherwise held.
  - SEED (1 cycle):
    - lfsr_load=1, lfsr_seed=captured seed, signature<=0, pattern_count<=0.
    - num_patterns=0 -> COMPARE; otherwise -> RUN.
  - RUN:
    - Each cycle: signature absorbs cut_resp; pattern_count increments.
    - lfsr_en=1 in every RUN cycle except the one where pattern_count==num_patterns-1.
    - That last cycle -> COMPARE.
    - The first RUN cycle sees pattern 0 = seed (loaded at the SEED edge).
  - COMPARE (1 cycle):
    - done<=1, pass<=(signature==golden_sig) -> DONE.
- Signature update (serial shift, right, with feedback):
  - next[WIDTH-1] = sig[0] ^ cut_resp
  - next[WIDTH-2] = sig[WIDTH-1] ^ sig[0]
  - next[k] = sig[k+1] for k < WIDTH-2
- Latency: start sampled at edge E -> SEED during cycle E+1 -> N RUN cycles -> COMPARE -> done=1 visible N+3 cycles after E.
- lfsr_load and lfsr_en are never both 1; both are 0 outside SEED/RUN.
- abort=1 in any state:
  - Next state IDLE; busy=0, done=0, pass=0, lfsr_en=0, lfsr_load=0.
  - signature and pattern_count hold their last values.
  - abort has priority over start in the same cycle.
- start while busy: ignored; captured inputs are not re-sampled.
- pattern_count saturates logically at num_patterns; no wrap is possible. num_patterns=2^CNT_W-1 is legal.
- Mid-session changes on seed/num_patterns/golden_sig have no effect.
- Reset asserted mid-session: immediate return to reset values, regardless of state.

Test Plan:
1. Reset then WIDTH=4, seed=4'b0001, num_patterns=0, golden=0, start -> SEED one cycle with lfsr_load=1, lfsr_seed=0001; no lfsr_en pulses; done=1, pass=1, signature=0000, 3 cycles after start.
2. num_patterns=5, cut_resp=1 on first RUN cycle only, else 0, golden=4'b1100 -> signature sequence 1000,0100,0010,0001,1100. lfsr_en high on 4 cycles; pattern_count=5; done=1, pass=1 at cycle 8 after start.
3. Same as 2 with golden=4'b1101 -> done=1, pass=0, signature=1100.
4. num_patterns=10, abort asserted in 3rd RUN cycle together with start=1 -> next cycle IDLE, busy=0, done=0, lfsr_en=0, pattern_count=2; session restarts only on a later start.
5. start pulsed again during RUN with different seed/num_patterns -> ignored; session completes with the original N, and lfsr_load pulses exactly once.
6. rst_n dropped asynchronously mid-RUN (between edges) -> all outputs 0 immediately. After release, a start with num_patterns=1, cut_resp=1 -> signature=1000, pass iff golden=1000.
